// File: rtl/tlm_hop_stamper.sv
// ---------------------------------------------------------------------------
// tlm_hop_stamper
//
// Sits between the telemetry arbiter and the comm transmit port. Every word
// accepted from the arbiter has its target (hop) field incremented. Words
// whose incremented hop count exceeds MAX_HOPS are consumed and dropped.
// All other words go into a two-entry FIFO that feeds the transmitter.
// Saturating forward and drop counters and a sticky drop flag are kept for
// the status registers.
//
// Ports
//   clock         system clock (16 MHz); all state changes on its rising edge
//   reset         asynchronous, active-high reset
//   din_target    target field from the arbiter (local words arrive as -1)
//   din_payload   payload from the arbiter
//   din_val       input word valid
//   din_rdy       stamper can accept a word this cycle
//   dout_target   incremented target of the head entry
//   dout_payload  payload of the head entry
//   dout_val      head entry valid
//   dout_rdy      transmitter takes the head entry this cycle
//   cnt_clear     synchronous clear of the counters and the sticky flag
//   fwd_count     words handed to the transmitter, saturating at 0xFFFF
//   drop_count    words dropped for hop overflow, saturating at 0xFFFF
//   drop_seen     sticky flag, set on any drop
//   buf_state     debug view of the buffer state (0 EMPTY, 1 ONE, 2 FULL)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A valid word and its fields are held stable until that
// transfer. Ready never depends on the partner's valid. In particular,
// din_rdy is decoded from the registered buffer state only.
// ---------------------------------------------------------------------------
module tlm_hop_stamper #(
   parameter int TARGET_W  = 8,
   parameter int PAYLOAD_W = 32,
   parameter int MAX_HOPS  = 63
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [TARGET_W-1:0]  din_target,
   input  logic [PAYLOAD_W-1:0] din_payload,
   input  logic                 din_val,
   output logic                 din_rdy,
   output logic [TARGET_W-1:0]  dout_target,
   output logic [PAYLOAD_W-1:0] dout_payload,
   output logic                 dout_val,
   input  logic                 dout_rdy,
   input  logic                 cnt_clear,
   output logic [15:0]          fwd_count,
   output logic [15:0]          drop_count,
   output logic                 drop_seen,
   output logic [1:0]           buf_state
);

   localparam int ENTRY_W = TARGET_W + PAYLOAD_W;
   localparam logic [31:0] MAX_HOPS_U = 32'(MAX_HOPS);

   // The encoding equals the occupancy of the FIFO.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_t;

   buf_state_t         state;
   logic [ENTRY_W-1:0] mem [2];
   logic               rd_ptr;
   logic               wr_ptr;

   logic [TARGET_W-1:0] incr;
   logic [31:0]         incr_ext;
   logic                accept;
   logic                keep;
   logic                push;
   logic                drop;
   logic                pop;

   assign din_rdy   = (state != FULL);
   assign dout_val  = (state != EMPTY);
   assign buf_state = state;

   // Local words (all-ones) wrap to 0, so they are always legal.
   assign incr     = din_target + 1'b1;
   assign incr_ext = 32'(incr);
   assign keep     = (incr_ext <= MAX_HOPS_U);

   assign accept = din_val && din_rdy;
   assign push   = accept && keep;
   assign drop   = accept && !keep;
   assign pop    = dout_val && dout_rdy;

   // The outputs are driven from storage only. There is no path from din_*
   // to dout_*. The head entry stays fixed until it is popped.
   assign {dout_target, dout_payload} = mem[rd_ptr];

   // Buffer state machine, together with its storage and pointers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {incr, din_payload};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case (state)
            EMPTY: begin
               if (push) state <= ONE;
            end
            ONE: begin
               if (push && !pop)      state <= FULL;
               else if (pop && !push) state <= EMPTY;
            end
            FULL: begin
               // din_rdy is low here, so only a pop can happen.
               if (pop) state <= ONE;
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // Status counters. A clear takes priority over an increment in the same
   // cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fwd_count  <= 16'd0;
         drop_count <= 16'd0;
         drop_seen  <= 1'b0;
      end else if (cnt_clear) begin
         fwd_count  <= 16'd0;
         drop_count <= 16'd0;
         drop_seen  <= 1'b0;
      end else begin
         if (pop && (fwd_count != 16'hFFFF)) begin
            fwd_count <= fwd_count + 16'd1;
         end
         if (drop) begin
            drop_seen <= 1'b1;
            if (drop_count != 16'hFFFF) begin
               drop_count <= drop_count + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tlm_hop_stamper.sv
module tb_tlm_hop_stamper;

  localparam int TW = 8;
  localparam int PW = 32;
  localparam int EW = TW + PW;
  localparam int MAXH = 63;

  logic          clock;
  logic          reset;
  logic [TW-1:0] din_target;
  logic [PW-1:0] din_payload;
  logic          din_val;
  logic          din_rdy;
  logic [TW-1:0] dout_target;
  logic [PW-1:0] dout_payload;
  logic          dout_val;
  logic          dout_rdy;
  logic          cnt_clear;
  logic [15:0]   fwd_count;
  logic [15:0]   drop_count;
  logic          drop_seen;
  logic [1:0]    buf_state;

  int checks;
  int errors;

  // Reference model: queue of expected words plus counters.
  logic [EW-1:0] exp_q[$];
  logic [15:0]   m_fwd;
  logic [15:0]   m_drop;
  logic          m_seen;

  tlm_hop_stamper #(.TARGET_W(TW), .PAYLOAD_W(PW), .MAX_HOPS(MAXH)) dut (
    .clock(clock), .reset(reset),
    .din_target(din_target), .din_payload(din_payload),
    .din_val(din_val), .din_rdy(din_rdy),
    .dout_target(dout_target), .dout_payload(dout_payload),
    .dout_val(dout_val), .dout_rdy(dout_rdy),
    .cnt_clear(cnt_clear),
    .fwd_count(fwd_count), .drop_count(drop_count), .drop_seen(drop_seen),
    .buf_state(buf_state)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Driver: called just after a falling edge. It drives one cycle, scores
  // the outputs before the rising edge, updates the model, and returns after
  // the next falling edge with the counters checked.
  task automatic step(input logic val, input logic [TW-1:0] tgt,
                      input logic [PW-1:0] pay, input logic rdy, input logic clr,
                      output logic acc, output logic popped,
                      output logic [TW-1:0] pop_tgt);
    logic [TW-1:0] inc;
    logic          exp_rdy;
    din_val = val; din_target = tgt; din_payload = pay;
    dout_rdy = rdy; cnt_clear = clr;
    #1;
    exp_rdy = (exp_q.size() < 2);
    checks++;
    if (din_rdy !== exp_rdy) begin
      errors++;
      $display("FAIL din_rdy: got %0b expected %0b", din_rdy, exp_rdy);
    end
    checks++;
    if (dout_val !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL dout_val: got %0b expected %0b", dout_val, exp_q.size() != 0);
    end
    acc = val && exp_rdy;
    popped = 1'b0;
    pop_tgt = '0;
    if (exp_q.size() != 0) begin
      checks++;
      if ({dout_target, dout_payload} !== exp_q[0]) begin
        errors++;
        $display("FAIL head_word: got %0h expected %0h", {dout_target, dout_payload}, exp_q[0]);
      end
      if (rdy) begin
        popped = 1'b1;
        pop_tgt = dout_target;
        void'(exp_q.pop_front());
        if (m_fwd != 16'hFFFF) m_fwd++;
      end
    end
    if (acc) begin
      inc = tgt + 8'd1;
      if (int'(inc) > MAXH) begin
        m_seen = 1'b1;
        if (m_drop != 16'hFFFF) m_drop++;
      end else begin
        exp_q.push_back({inc, pay});
      end
    end
    if (clr) begin
      m_fwd = 16'd0; m_drop = 16'd0; m_seen = 1'b0;
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({fwd_count, drop_count, drop_seen} !== {m_fwd, m_drop, m_seen}) begin
      errors++;
      $display("FAIL counters: got fwd=%0h drop=%0h seen=%0b expected fwd=%0h drop=%0h seen=%0b",
               fwd_count, drop_count, drop_seen, m_fwd, m_drop, m_seen);
    end
  endtask

  task automatic idle(input int n);
    logic a, p;
    logic [TW-1:0] t;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0, a, p, t);
  endtask

  task automatic clear_counters();
    logic a, p;
    logic [TW-1:0] t;
    step(1'b0, '0, '0, 1'b1, 1'b1, a, p, t);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din_val = 1'b0; din_target = '0; din_payload = '0;
    dout_rdy = 1'b0; cnt_clear = 1'b0;
    exp_q.delete();
    m_fwd = 0; m_drop = 0; m_seen = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({dout_val, dout_target, dout_payload} !== {1'b0, {TW{1'b0}}, {PW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_dout: got val=%0b tgt=%0h pay=%0h expected all zero",
               dout_val, dout_target, dout_payload);
    end
    checks++;
    if ({din_rdy, fwd_count, drop_count, drop_seen, buf_state} !== {1'b1, 16'd0, 16'd0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_status: got rdy=%0b fwd=%0h drop=%0h seen=%0b st=%0d expected rdy=1 rest 0",
               din_rdy, fwd_count, drop_count, drop_seen, buf_state);
    end
    @(negedge clock);
  endtask

  task automatic test_local();
    logic a, p;
    logic [TW-1:0] t;
    clear_counters();
    step(1'b1, 8'hFF, 32'hDEADBEEF, 1'b1, 1'b0, a, p, t);
    checks++;
    if ({dout_val, dout_target, dout_payload} !== {1'b1, 8'h00, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL local_word: got val=%0b tgt=%0h pay=%0h expected val=1 tgt=0 pay=deadbeef",
               dout_val, dout_target, dout_payload);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, a, p, t);
    checks++;
    if ({dout_val, fwd_count} !== {1'b0, 16'd1}) begin
      errors++;
      $display("FAIL local_after: got val=%0b fwd=%0d expected val=0 fwd=1", dout_val, fwd_count);
    end
  endtask

  task automatic test_hop_limit();
    logic a, p;
    logic [TW-1:0] t;
    logic [TW-1:0] tg[3] = '{8'd62, 8'd63, 8'hFE};
    clear_counters();
    for (int i = 0; i < 3; i++) step(1'b1, tg[i], $urandom, 1'b1, 1'b0, a, p, t);
    idle(2);
    checks++;
    if ({drop_count, drop_seen, fwd_count} !== {16'd2, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL hop_limit: got drop=%0d seen=%0b fwd=%0d expected drop=2 seen=1 fwd=1",
               drop_count, drop_seen, fwd_count);
    end
  endtask

  task automatic test_back_to_back();
    logic a, p;
    logic [TW-1:0] t;
    logic [TW-1:0] got[$];
    int guard;
    step(1'b1, 8'd1, $urandom, 1'b0, 1'b0, a, p, t);
    step(1'b1, 8'd2, $urandom, 1'b0, 1'b0, a, p, t);
    step(1'b1, 8'd3, $urandom, 1'b0, 1'b0, a, p, t);
    checks++;
    if ({a, din_rdy, dout_target, buf_state} !== {1'b0, 1'b0, 8'd2, 2'd2}) begin
      errors++;
      $display("FAIL backpressure_hold: got acc=%0b rdy=%0b tgt=%0d st=%0d expected acc=0 rdy=0 tgt=2 st=2",
               a, din_rdy, dout_target, buf_state);
    end
    a = 1'b0;
    guard = 0;
    while (!a && guard < 8) begin
      step(1'b1, 8'd3, 32'h33, 1'b1, 1'b0, a, p, t);
      if (p) got.push_back(t);
      guard++;
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 8) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, a, p, t);
      if (p) got.push_back(t);
      guard++;
    end
    checks++;
    if (got.size() != 3 || got[0] !== 8'd2 || got[1] !== 8'd3 || got[2] !== 8'd4) begin
      errors++;
      $display("FAIL backpressure_order: got %p expected 2 3 4", got);
    end
  endtask

  task automatic test_random();
    logic a, p;
    logic [TW-1:0] t, tg;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: tg = TW'($urandom);
        1: tg = TW'(61 + $urandom_range(0, 3));
        2: tg = 8'hFF;
        default: tg = 8'hFE;
      endcase
      step($urandom_range(0, 3) != 0, tg, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0, a, p, t);
    end
    idle(3);
  endtask

  task automatic test_saturation();
    logic a, p;
    logic [TW-1:0] t;
    clear_counters();
    for (int i = 0; i < 65540; i++)
      step(1'b1, TW'($urandom_range(0, 62)), $urandom, 1'b1, 1'b0, a, p, t);
    idle(2);
    checks++;
    if (fwd_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL fwd_saturate: got %0h expected ffff", fwd_count);
    end
    step(1'b1, 8'd63, $urandom, 1'b1, 1'b0, a, p, t);
    checks++;
    if ({drop_count, drop_seen} !== {16'd1, 1'b1}) begin
      errors++;
      $display("FAIL drop_before_clear: got drop=%0d seen=%0b expected 1 1", drop_count, drop_seen);
    end
    step(1'b1, 8'd63, $urandom, 1'b1, 1'b1, a, p, t);
    checks++;
    if ({drop_count, drop_seen, fwd_count} !== {16'd0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL clear_wins: got drop=%0d seen=%0b fwd=%0d expected 0 0 0",
               drop_count, drop_seen, fwd_count);
    end
  endtask

  task automatic test_reset_mid();
    logic a, p;
    logic [TW-1:0] t;
    step(1'b1, 8'd10, $urandom, 1'b0, 1'b0, a, p, t);
    step(1'b1, 8'd20, $urandom, 1'b0, 1'b0, a, p, t);
    checks++;
    if (buf_state !== 2'd2 || dout_val !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got st=%0d val=%0b expected st=2 val=1", buf_state, dout_val);
    end
    din_val = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({dout_val, dout_target, dout_payload} !== {1'b0, {TW{1'b0}}, {PW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_async: got val=%0b tgt=%0h pay=%0h expected all zero",
               dout_val, dout_target, dout_payload);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    m_fwd = 0; m_drop = 0; m_seen = 0;
    #1;
    checks++;
    if ({din_rdy, fwd_count, drop_count, drop_seen} !== {1'b1, 16'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: got rdy=%0b fwd=%0h drop=%0h seen=%0b expected rdy=1 rest 0",
               din_rdy, fwd_count, drop_count, drop_seen);
    end
    @(negedge clock);
    idle(3);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_local();
    test_hop_limit();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
